pipe_ctrl: RTL and testbench

Pipeline control sequencer for the 5-stage RV32I core. Collects stall/flush requests from the hazard unit (load-use, branch redirect), the LSU (data-memory wait) and the multi-cycle mul/div unit. Resolves them by fixed priority into per-stage stall/flush controls for the F/D, D/E, E/M and M/W pipeline registers. Holds the mul/div wait FSM with a timeout watchdog.

---
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage RV32I core, with mul/div wait FSM and watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned PERF_W     = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic lw_stall_D,
  input  logic br_sel,
  input  logic lsu_req_M,
  input  logic lsu_ack_M,
  input  logic md_start_E,
  input  logic md_done,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic FlushD,
  output logic FlushE,
  output logic FlushM,
  output logic FlushW,
  output logic pc_redirect_F,
  output logic md_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  if (MD_TIMEOUT < 1 || MD_TIMEOUT > 1023 || PERF_W < 1) begin : g_param_check
    $error("pipe_ctrl: MD_TIMEOUT must be 1..1023 and PERF_W at least 1");
  end

  localparam logic [9:0] MD_LAST = 10'(MD_TIMEOUT - 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  state_e     state_q;
  logic [9:0] md_cnt_q;
  logic       in_wait_s;
  logic       expire_s;
  logic       mem_s;
  logic       md_s;

  // Request decode; the watchdog can only expire while waiting on mul/div.
  always_comb begin
    in_wait_s = (state_q == MD_WAIT);
    expire_s  = in_wait_s && (md_cnt_q == MD_LAST);
    mem_s     = lsu_req_M & ~lsu_ack_M;
    md_s      = (~in_wait_s & md_start_E & ~md_done) |
                (in_wait_s & ~md_done & ~expire_s);
  end

  // Fixed-priority resolution: MEM, then MD, then branch, then load-use.
  always_comb begin
    StallF        = 1'b0;
    StallD        = 1'b0;
    StallE        = 1'b0;
    StallM        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    FlushM        = 1'b0;
    FlushW        = 1'b0;
    pc_redirect_F = 1'b0;
    md_timeout    = 1'b0;
    if (!i_rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      md_timeout = expire_s;
      if (mem_s) begin
        // Only W is bubbled so a branch waiting in E survives the memory stall.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (md_s) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (br_sel) begin
        FlushD        = 1'b1;
        FlushE        = 1'b1;
        pc_redirect_F = 1'b1;
      end else if (lw_stall_D) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = 1'b0;
      end
    end
  end

  // Mul/div wait FSM and watchdog counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= 10'd0;
    end else begin
      case (state_q)
        RUN: begin
          md_cnt_q <= 10'd0;
          if (md_start_E && !md_done && !mem_s) begin
            state_q <= MD_WAIT;
          end else begin
            state_q <= RUN;
          end
        end
        MD_WAIT: begin
          if (md_done || expire_s) begin
            state_q  <= RUN;
            md_cnt_q <= 10'd0;
          end else begin
            state_q  <= MD_WAIT;
            md_cnt_q <= md_cnt_q + 10'd1;
          end
        end
        default: begin
          state_q  <= RUN;
          md_cnt_q <= 10'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q;
  logic [PERF_W-1:0] flush_cnt_d;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    if (en && (v != {PERF_W{1'b1}})) begin
      return v + PERF_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Saturating event counters; reset-forced flushes never reach them.
  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, StallF);
    flush_cnt_d = sat_inc(flush_cnt_q, FlushE & i_rst_n);
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs, a negedge monitor compares.
module tb_pipe_ctrl;

  localparam int unsigned TO = 8;
  localparam int unsigned PW = 4;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,pc_redirect_F,md_timeout}
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_LU   = 10'b1100010000;
  localparam logic [9:0] O_BR   = 10'b0000110010;
  localparam logic [9:0] O_MD   = 10'b1110001000;
  localparam logic [9:0] O_MEM  = 10'b1111000100;
  localparam logic [9:0] O_RST  = 10'b0000111100;
  localparam logic [9:0] O_TO   = 10'b0000000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lw = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0, st = 1'b0, dn = 1'b0;
  logic sF, sD, sE, sM, fD, fE, fM, fW, redir, mto;
  logic [9:0] act;
`ifdef PIPE_CTRL_PERF_EN
  logic [PW-1:0] p_stall, p_flush;
  logic [PW-1:0] m_stall = '0, m_flush = '0;
  logic perf_valid = 1'b0;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [9:0] exp_q[$];
  logic       rst_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_TIMEOUT(TO), .PERF_W(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .lw_stall_D(lw), .br_sel(br), .lsu_req_M(req), .lsu_ack_M(ack),
    .md_start_E(st), .md_done(dn),
    .StallF(sF), .StallD(sD), .StallE(sE), .StallM(sM),
    .FlushD(fD), .FlushE(fE), .FlushM(fM), .FlushW(fW),
    .pc_redirect_F(redir), .md_timeout(mto)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(p_stall), .perf_flush_cnt(p_flush)
`endif
  );

  assign act = {sF, sD, sE, sM, fD, fE, fM, fW, redir, mto};

  task automatic step(input logic r, input logic l, input logic b, input logic q,
                      input logic a, input logic s, input logic d,
                      input logic [9:0] e, input string nm);
    @(posedge clk);
    #1;
    rst_n = r; lw = l; br = b; req = q; ack = a; st = s; dn = d;
    exp_q.push_back(e);
    rst_q.push_back(~r);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, nm);
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  initial begin
    logic [9:0] e;
    logic       r;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        r  = rst_q.pop_front();
        nm = name_q.pop_front();
        n_total++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, e);
`ifdef PIPE_CTRL_PERF_EN
        if (perf_valid) begin
          n_total++;
          if (p_stall === m_stall && p_flush === m_flush) n_pass++;
          else $display("FAIL perf_%s: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                        nm, p_stall, p_flush, m_stall, m_flush);
        end
        if (r) begin
          m_stall    = '0;
          m_flush    = '0;
          perf_valid = 1'b1;
        end else begin
          if (e[9] && m_stall != {PW{1'b1}}) m_stall = m_stall + 1'b1;
          if (e[4] && m_flush != {PW{1'b1}}) m_flush = m_flush + 1'b1;
        end
`endif
      end
    end
  end

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, "reset0");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_RST, "reset_forced");
    idle("post_reset");
    // Load-use
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU, "load_use");
    idle("load_use_next");
    // Branch beats load-use
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_BR, "br_vs_lu");
    idle("br_next");
    // Mul/div finishing on cycle 5
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MD, $sformatf("md_wait_c%0d", i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, "md_done_c5");
    idle("md_run_c6");
    // Single-cycle op and stray md_done
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, "md_single");
    idle("md_single_next");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "md_done_ignored");
    idle("md_done_ignored_next");
    // Watchdog expiry with md_done never arriving
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MD, "wd_c0");
    for (int i = 1; i < 8; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MD, $sformatf("wd_c%0d", i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_TO, "wd_expire_c8");
    idle("wd_run_c9");
    // Memory wait holding a branch
    for (int i = 1; i <= 3; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_MEM, $sformatf("mem_br_c%0d", i));
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_BR, "mem_ack_redirect");
    idle("mem_br_after");
    // MEM while in MD_WAIT: MEM wins, wait persists
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MD, "mdmem_enter");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_MEM, "mdmem_mem1");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_MEM, "mdmem_mem2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MD, "mdmem_still_wait");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE, "mdmem_done");
    idle("mdmem_after");
    // Reset in the middle of a wait, then a full watchdog run from a clean counter
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MD, "rstw_enter");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MD, "rstw_wait");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RST, "rstw_reset");
    idle("rstw_run");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_MD, "wd2_c0");
    for (int i = 1; i < 8; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_MD, $sformatf("wd2_c%0d", i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_TO, "wd2_expire_c8");
    idle("wd2_run_c9");
    idle("final_idle");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
